// File: rtl/sram_host_ctrl_pkg.sv
// Shared definitions for the SRAM host controller: default geometry and
// timing, one-hot state encodings, and a small helper for sizing the
// shared timing counter.
package sram_host_ctrl_pkg;

  localparam int ADDR_W_DEF       = 12;
  localparam int DATA_W_DEF       = 8;
  localparam int WR_PULSE_DEF     = 2;
  localparam int RD_WAIT_DEF      = 2;
  localparam int TURN_DEF         = 2;
  localparam int MIN_TIMING       = 1;

  typedef logic [5:0] state_t;

  localparam state_t ST_IDLE      = 6'b000001;
  localparam state_t ST_WR_SETUP  = 6'b000010;
  localparam state_t ST_WR_PULSE  = 6'b000100;
  localparam state_t ST_WR_HOLD   = 6'b001000;
  localparam state_t ST_RD_ACCESS = 6'b010000;
  localparam state_t ST_TURN      = 6'b100000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_host_ctrl_if.sv
// Host-side request/response bundle for the SRAM controller: single-beat
// valid/ready requests in, one-cycle read-data pulses out.
interface sram_host_ctrl_if
  import sram_host_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/sram_host_ctrl_iobuf.sv
// Tri-state buffer for the SRAM data bus. This is the only place the bus
// is released to high impedance; everything else sees plain logic.
module sram_dbus_iobuf #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] dout,
  input  logic              oe,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] sram_dbus
);

  // Drive the bus only while the controller owns it.
  assign sram_dbus = oe ? dout : {DATA_W{1'bz}};

  // The bus is always observable for read sampling.
  assign din = sram_dbus;

endmodule

// File: rtl/sram_host_ctrl.sv
// Synchronous initiator for a 4K x 8 asynchronous SRAM. Turns single-beat
// valid/ready read and write requests into timed CSB/WRB strobe sequences,
// owns the data-bus direction and enforces a turnaround gap after reads so
// the SRAM has released the bus before the controller drives it again.
module sram_host_ctrl
  import sram_host_ctrl_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int WR_PULSE_CYCLES = WR_PULSE_DEF,
  parameter int RD_WAIT_CYCLES  = RD_WAIT_DEF,
  parameter int TURN_CYCLES     = TURN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  sram_host_ctrl_if.slave   host,
  output logic              sram_csb,
  output logic              sram_wrb,
  output logic [ADDR_W-1:0] sram_abus,
  inout  wire  [DATA_W-1:0] sram_dbus
);

  localparam int CNT_MAX = max3(WR_PULSE_CYCLES, RD_WAIT_CYCLES, TURN_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

  generate
    if (WR_PULSE_CYCLES < MIN_TIMING || RD_WAIT_CYCLES < MIN_TIMING ||
        TURN_CYCLES < MIN_TIMING) begin : g_bad_timing
      $error("sram_host_ctrl: WR_PULSE_CYCLES, RD_WAIT_CYCLES and TURN_CYCLES must all be >= 1");
    end
  endgenerate

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] din;
  logic              dbus_oe;

  sram_dbus_iobuf #(
    .DATA_W (DATA_W)
  ) u_iobuf (
    .dout      (dout),
    .oe        (dbus_oe),
    .din       (din),
    .sram_dbus (sram_dbus)
  );

  // Strobe sequencer: one timed state at a time, all outputs registered,
  // a single down-counter reloaded on entry to each timed state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      dout          <= '0;
      dbus_oe       <= 1'b0;
      sram_csb      <= 1'b1;
      sram_wrb      <= 1'b1;
      sram_abus     <= '0;
      host.req_ready <= 1'b1;
      host.rd_valid  <= 1'b0;
      host.rd_data   <= '0;
    end else begin
      host.rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (host.req_valid && host.req_ready) begin
            host.req_ready <= 1'b0;
            sram_abus      <= host.req_addr;
            if (host.req_we) begin
              state   <= ST_WR_SETUP;
              dout    <= host.req_wdata;
              dbus_oe <= 1'b1;
            end else begin
              state    <= ST_RD_ACCESS;
              sram_csb <= 1'b0;
              cnt      <= RD_LOAD;
            end
          end
        end
        ST_WR_SETUP: begin
          state    <= ST_WR_PULSE;
          sram_csb <= 1'b0;
          sram_wrb <= 1'b0;
          cnt      <= WR_LOAD;
        end
        ST_WR_PULSE: begin
          if (cnt == '0) begin
            state    <= ST_WR_HOLD;
            sram_csb <= 1'b1;
            sram_wrb <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WR_HOLD: begin
          state          <= ST_IDLE;
          dbus_oe        <= 1'b0;
          host.req_ready <= 1'b1;
        end
        ST_RD_ACCESS: begin
          if (cnt == '0) begin
            state         <= ST_TURN;
            host.rd_data  <= din;
            host.rd_valid <= 1'b1;
            sram_csb      <= 1'b1;
            cnt           <= TURN_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_TURN: begin
          if (cnt == '0) begin
            state          <= ST_IDLE;
            host.req_ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state          <= ST_IDLE;
          dbus_oe        <= 1'b0;
          sram_csb       <= 1'b1;
          sram_wrb       <= 1'b1;
          host.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_host_ctrl.sv
// Bench for sram_host_ctrl: behavioural SRAM on the bus, a reference memory
// updated at request acceptance, a scoreboard of expected reads, and a
// monitor that checks read data/latency and strobe timing on its own.
module tb_sram_host_ctrl;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int EXP_WR_PULSE = 2;
  localparam int EXP_RD_LAT   = 2;
  localparam int EXP_BUSY     = 4;
  localparam int EXP_TURN     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          sram_csb;
  logic          sram_wrb;
  logic [AW-1:0] sram_abus;
  wire  [DW-1:0] sram_dbus;

  sram_host_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) host ();

  sram_host_ctrl #(
    .ADDR_W          (AW),
    .DATA_W          (DW),
    .WR_PULSE_CYCLES (2),
    .RD_WAIT_CYCLES  (2),
    .TURN_CYCLES     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (host),
    .sram_csb  (sram_csb),
    .sram_wrb  (sram_wrb),
    .sram_abus (sram_abus),
    .sram_dbus (sram_dbus)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM: drives data while selected for read,
  // latches the bus on the rising edge of the write strobe.
  logic [DW-1:0] sramMem [0:(1<<AW)-1];
  assign sram_dbus = (!sram_csb && sram_wrb) ? sramMem[sram_abus] : {DW{1'bz}};
  always @(posedge sram_wrb) begin
    if (!rst) sramMem[sram_abus] = sram_dbus;
  end

  // Reference memory and scoreboard.
  typedef struct {
    logic [DW-1:0] data;
    bit            known;
    int            acceptCycle;
  } exp_t;

  logic [DW-1:0] refMem   [0:(1<<AW)-1];
  bit            refKnown [0:(1<<AW)-1];
  exp_t          expQ[$];
  logic [DW-1:0] curWrData = '0;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int wrbFalls = 0;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic randomizeIdleInputs();
    host.req_we    = 1'($urandom);
    host.req_addr  = AW'($urandom);
    host.req_wdata = DW'($urandom);
  endtask

  // Present one request, wait (bounded) for acceptance, update the model.
  task automatic applyStimulus(input bit we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input bit track);
    int budget;
    @(negedge clk);
    host.req_valid = 1'b1;
    host.req_we    = we;
    host.req_addr  = addr;
    host.req_wdata = data;
    budget = 0;
    while (host.req_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) begin
      checkOutput("ready_timeout", 32'(host.req_ready), 32'd1);
      host.req_valid = 1'b0;
      return;
    end
    if (we) begin
      refMem[addr]   = data;
      refKnown[addr] = 1'b1;
      curWrData      = data;
    end else if (track) begin
      expQ.push_back('{data: refMem[addr], known: refKnown[addr],
                       acceptCycle: cycleCount + 1});
    end
    @(posedge clk);
    #1;
    host.req_valid = 1'b0;
    randomizeIdleInputs();
  endtask

  // Outputs expected one edge after a synchronous reset.
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_csb"},      32'(sram_csb), 32'd1);
    checkOutput({tag, "_wrb"},      32'(sram_wrb), 32'd1);
    checkOutput({tag, "_dbus_z"},   32'(sram_dbus), 32'({DW{1'bz}}));
    checkOutput({tag, "_rd_valid"}, 32'(host.rd_valid), 32'd0);
    checkOutput({tag, "_ready"},    32'(host.req_ready), 32'd1);
  endtask

  // Monitor: pops the scoreboard on every rd_valid pulse and checks the
  // strobe and handshake timing rules every cycle outside reset.
  initial begin : monitor
    int   wrbLow;
    int   busyRun;
    int   turnLeft;
    exp_t e;
    wrbLow = 0;
    busyRun = 0;
    turnLeft = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wrbLow = 0;
        busyRun = 0;
        turnLeft = 0;
      end else begin
        if (host.rd_valid) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_rd_valid", 32'(host.rd_valid), 32'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("rd_latency", 32'(cycleCount - e.acceptCycle), 32'(EXP_RD_LAT));
            if (e.known) checkOutput("rd_data", 32'(host.rd_data), 32'(e.data));
          end
          turnLeft = EXP_TURN;
        end
        if (turnLeft > 0) begin
          checkOutput("turn_ready", 32'(host.req_ready), 32'd0);
          turnLeft--;
        end
        if (!sram_wrb) begin
          if (wrbLow == 0) wrbFalls++;
          wrbLow++;
          checkOutput("wrb_needs_csb", 32'(sram_csb), 32'd0);
          checkOutput("wr_dbus", 32'(sram_dbus), 32'(curWrData));
        end else if (wrbLow > 0) begin
          checkOutput("wrb_width", 32'(wrbLow), 32'(EXP_WR_PULSE));
          wrbLow = 0;
        end
        if (!host.req_ready) begin
          busyRun++;
        end else if (busyRun > 0) begin
          checkOutput("busy_cycles", 32'(busyRun), 32'(EXP_BUSY));
          busyRun = 0;
        end
      end
    end
  end

  logic [AW-1:0] pool [0:7];

  initial begin : stimulus
    int budget;
    int fallsBefore;
    logic [AW-1:0] a;

    for (int i = 0; i < (1 << AW); i++) begin
      sramMem[i]  = '0;
      refMem[i]   = '0;
      refKnown[i] = 1'b1;
    end
    host.req_valid = 1'b0;
    randomizeIdleInputs();

    // Reset with random inputs for three cycles.
    repeat (3) begin
      @(negedge clk);
      host.req_valid = 1'($urandom);
      randomizeIdleInputs();
    end
    #2;
    host.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checkResetState("reset");
    checkOutput("reset_abus",    32'(sram_abus), 32'd0);
    checkOutput("reset_rd_data", 32'(host.rd_data), 32'd0);

    // Basic write then read.
    applyStimulus(1'b1, 12'h123, 8'hA5, 1'b1);
    applyStimulus(1'b0, 12'h123, 8'h00, 1'b1);

    // Address extremes and untouched neighbours.
    applyStimulus(1'b1, 12'h000, 8'h11, 1'b1);
    applyStimulus(1'b1, 12'hFFF, 8'hEE, 1'b1);
    applyStimulus(1'b0, 12'h000, 8'h00, 1'b1);
    applyStimulus(1'b0, 12'hFFF, 8'h00, 1'b1);
    applyStimulus(1'b0, 12'h001, 8'h00, 1'b1);
    applyStimulus(1'b0, 12'hFFE, 8'h00, 1'b1);

    // Read immediately followed by a write to the same address.
    applyStimulus(1'b0, 12'h010, 8'h00, 1'b1);
    applyStimulus(1'b1, 12'h010, 8'h3C, 1'b1);
    applyStimulus(1'b0, 12'h010, 8'h00, 1'b1);

    // req_valid held high through a whole write: one access only.
    fallsBefore = wrbFalls;
    @(negedge clk);
    host.req_valid = 1'b1;
    host.req_we    = 1'b1;
    host.req_addr  = 12'h055;
    host.req_wdata = 8'h5A;
    budget = 0;
    while (host.req_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("hold_ready", 32'(host.req_ready), 32'd1);
    refMem[12'h055] = 8'h5A;
    refKnown[12'h055] = 1'b1;
    curWrData = 8'h5A;
    repeat (4) @(negedge clk);
    host.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("hold_one_access", 32'(wrbFalls - fallsBefore), 32'd1);
    applyStimulus(1'b0, 12'h055, 8'h00, 1'b1);

    // Reset in the middle of a write pulse.
    a = 12'h200;
    applyStimulus(1'b1, a, 8'hC3, 1'b0);
    refKnown[a] = 1'b0;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (sram_wrb !== 1'b0 && budget < 10);
    checkOutput("midwrite_wrb_low", 32'(sram_wrb), 32'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    checkResetState("rst_wr");
    #2 rst = 1'b0;
    applyStimulus(1'b1, 12'h201, 8'h77, 1'b1);
    applyStimulus(1'b0, 12'h201, 8'h00, 1'b1);

    // Reset in the middle of a read access: no rd_valid may follow.
    applyStimulus(1'b0, 12'h123, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("midread_csb_low", 32'(sram_csb), 32'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    checkResetState("rst_rd");
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 12'h123, 8'h00, 1'b1);

    // Randomized traffic over a small address pool plus occasional
    // arbitrary addresses.
    for (int i = 0; i < 8; i++) pool[i] = AW'($urandom);
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : pool[$urandom_range(0, 7)];
      applyStimulus(1'($urandom), a, DW'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Drain outstanding reads.
    budget = 0;
    while (expQ.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("queue_drain", 32'(expQ.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
